// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline control logic
// Contents: state_t (2-bit FSM encoding), DEFAULT_TIMEOUT_CYCLES,
//           WAIT_W (memory wait counter width), load_use_hazard() helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALT     = 2'b10
    } state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // Wide enough for the largest legal timeout (65535).
    localparam int WAIT_W = 16;

    // A load in EX whose destination is read by the instruction in ID.
    // x0 is hard-wired zero, so it never creates a dependency.
    function automatic logic load_use_hazard(
        input logic       memread,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs2
    );
        return memread && (rd != 5'd0) &&
               ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Ports: clk, reset (async active-low), inc (count enable),
//        clr (synchronous clear, wins over inc), q (count, sticks at all-ones).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, branch flush, memory wait
// Ports: clk, reset (async active-low);
//        id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2, if_id_uses_rs2 (load-use detection);
//        branch_taken; mem_req, mem_ready (data memory handshake);
//        pc_write, if_id_write, id_ex_write, ex_mem_write (pipeline register enables);
//        if_id_flush, id_ex_flush (bubble insert); stall_cnt, lu_cnt, flush_cnt
//        (saturating performance counters); mem_timeout (sticky memory error).
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rd,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_uses_rs2,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    // Value the wait counter holds during the last MEM_WAIT cycle allowed.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_next;
    logic              pending_flush, pending_flush_next;
    logic              timeout_set;
    logic [WAIT_W-1:0] wait_q;
    logic              wait_inc, wait_clr;
    logic              stall_inc, lu_inc, flush_inc;
    logic              lu_hazard;
    logic              pc_w, if_id_w, id_ex_w, ex_mem_w, if_id_f, id_ex_f;

    assign lu_hazard = load_use_hazard(id_ex_memread, id_ex_rd, if_id_rs1,
                                       if_id_rs2, if_id_uses_rs2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_RUN;
            pending_flush <= 1'b0;
            mem_timeout   <= 1'b0;
        end else begin
            state         <= state_next;
            pending_flush <= pending_flush_next;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next         = state;
        pending_flush_next = pending_flush;
        timeout_set        = 1'b0;
        wait_inc           = 1'b0;
        wait_clr           = 1'b0;
        stall_inc          = 1'b0;
        lu_inc             = 1'b0;
        flush_inc          = 1'b0;
        pc_w               = 1'b0;
        if_id_w            = 1'b0;
        id_ex_w            = 1'b0;
        ex_mem_w           = 1'b0;
        if_id_f            = 1'b0;
        id_ex_f            = 1'b0;

        case (state)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    // Freeze everything; a same-cycle ready is not a stall.
                    wait_clr   = 1'b1;
                    state_next = ST_MEM_WAIT;
                end else if (branch_taken) begin
                    // Wrong-path instructions are squashed, so any load-use
                    // hazard they carry is irrelevant.
                    {pc_w, if_id_w, id_ex_w, ex_mem_w} = 4'b1111;
                    if_id_f   = 1'b1;
                    id_ex_f   = 1'b1;
                    flush_inc = 1'b1;
                end else if (lu_hazard) begin
                    // Hold PC and IF/ID, push a bubble into EX.
                    id_ex_w  = 1'b1;
                    ex_mem_w = 1'b1;
                    id_ex_f  = 1'b1;
                    lu_inc   = 1'b1;
                end else begin
                    {pc_w, if_id_w, id_ex_w, ex_mem_w} = 4'b1111;
                end
            end

            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    // A branch seen while frozen is applied on the release cycle.
                    {pc_w, if_id_w, id_ex_w, ex_mem_w} = 4'b1111;
                    if_id_f            = pending_flush || branch_taken;
                    id_ex_f            = pending_flush || branch_taken;
                    flush_inc          = pending_flush || branch_taken;
                    pending_flush_next = 1'b0;
                    state_next         = ST_RUN;
                end else begin
                    stall_inc          = 1'b1;
                    wait_inc           = 1'b1;
                    pending_flush_next = pending_flush || branch_taken;
                    if (wait_q == WAIT_LAST) begin
                        timeout_set = 1'b1;
                        state_next  = ST_HALT;
                    end
                end
            end

            ST_HALT: begin
                // Everything frozen until reset.
            end

            default: begin
                state_next = ST_HALT;
            end
        endcase
    end

    // Enables and flushes are forced low for as long as reset is held.
    assign pc_write     = reset && pc_w;
    assign if_id_write  = reset && if_id_w;
    assign id_ex_write  = reset && id_ex_w;
    assign ex_mem_write = reset && ex_mem_w;
    assign if_id_flush  = reset && if_id_f;
    assign id_ex_flush  = reset && id_ex_f;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .clr   (1'b0),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (lu_inc),
        .clr   (1'b0),
        .q     (lu_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .clr   (1'b0),
        .q     (flush_cnt)
    );

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wait_inc),
        .clr   (wait_clr),
        .q     (wait_q)
    );

endmodule
